ir_imm_decode: RTL and testbench
================================

// Module: ir_imm_decode
// PURPOSE
//  Upstream feeder of the SEXT sign-extender in the LC-3b datapath. Latches fetched instructions,
//  decodes opcode, extracts the raw immediate/offset field and produces the 4-bit SEXT cont code plus
//  LSHF1 flag. Two-entry skid buffer with valid/ready on both sides: full throughput, registered in_ready.
// PARAMETERS
//  PC_W          16      width of in_pc/out_pc
//  ILLEGAL_CONT  4'd15   sext_cont emitted for reserved opcodes 1010/1011
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  reset      in   1     synchronous, active-high reset
//  flush      in   1     drop all buffered entries (branch redirect)
//  in_valid   in   1     fetch word valid
//  in_ready   out  1     buffer can accept (registered)
//  in_instr   in   16    instruction word
//  in_pc      in   PC_W  PC of in_instr
//  out_valid  out  1     decoded entry valid
//  out_ready  in   1     downstream accepts
//  out_ir     out  16    instruction
//  out_pc     out  PC_W  PC of out_ir
//  out_opcode out  4     out_ir[15:12]
//  imm_raw    out  16    immediate field, upper bits zero; drives SEXT.in
//  sext_cont  out  4     drives SEXT.cont
//  lshf1      out  1     SEXT result to be shifted left 1 (word offsets)
//  has_imm    out  1     instruction uses an immediate
//  illegal    out  1     reserved opcode (only with ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  Reset: state EMPTY, in_ready=1, out_valid=0; out_ir/out_pc/imm_raw=0, sext_cont=4'd15, lshf1/has_imm/illegal=0.
//  Transfer in: in_valid&in_ready at edge; out: out_valid&out_ready at edge. Latency in->out 1 cycle.
//  FSM (occupancy): EMPTY -push-> ONE; ONE -push&!pop-> TWO; ONE -pop&!push-> EMPTY; ONE push&pop stays ONE
//   (new word replaces head); TWO -pop-> ONE (skid entry moves to head). TWO never accepts: in_ready=0 in TWO.
//  in_ready registered: 1 in EMPTY/ONE, 0 in TWO. out_valid=1 in ONE/TWO. Outputs come from head register only.
//  Decode done on entry into head (registered); outputs stable while out_valid&!out_ready.
//  Decode table (op: imm_raw, cont, lshf1, has_imm):
//   BR 0000, LEA 1110: ir[8:0], 8, 1, 1
//   ADD 0001, AND 0101, XOR 1001: ir[5]=1 -> ir[4:0], 4, 0, 1; ir[5]=0 -> 0, 15, 0, 0
//   LDB 0010, STB 0011: ir[5:0], 5, 0, 1;  LDW 0110, STW 0111: ir[5:0], 5, 1, 1
//   JSR 0100: ir[11]=1 -> ir[10:0], 10, 1, 1; ir[11]=0 -> 0, 15, 0, 0
//   SHF 1101: {12'b0,ir[3:0]}, 15, 0, 1 (zero-extended via pass-through)
//   TRAP 1111: {8'b0,ir[7:0]}, 15, 1, 1;  JMP 1100, RTI 1000: 0, 15, 0, 0
//   1010/1011: 0, ILLEGAL_CONT, 0, 0
//  flush: next state EMPTY, out_valid=0, in_ready=1; same-cycle push is discarded; flush wins over push/pop.
//  reset dominates flush; reset mid-transfer discards both entries.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: reserved opcode sets illegal=1 with its entry; entry is held (head never pops,
//   out_valid stays 1) until flush or reset; in_ready follows occupancy (skid fills, then stalls).
//  Undefined: illegal tied 0; reserved opcodes flow through as no-immediate entries.
// TESTING
//  ADD imm: in_instr=16'h1261 (ADD R1,R1,#1) -> next cycle out_valid=1, imm_raw=16'h0001, sext_cont=4, lshf1=0.
//  BR offset: 16'h0FFF -> imm_raw=16'h01FF, sext_cont=8, lshf1=1, has_imm=1.
//  Backpressure: out_ready=0, push A,B -> in_ready=0 after 2nd push, head=A; out_ready=1 -> A then B, no loss.
//  Stream: in_valid=1/out_ready=1 for 10 words -> 10 outputs on consecutive cycles, order preserved.
//  Flush with TWO occupied plus in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emitted.
//  Reserved 16'hA000 -> ILLEGAL_TRAP_EN: illegal=1, held until flush; else sext_cont=15, illegal=0, pops.

Source files
------------

// File: rtl/ir_imm_decode.sv
// rtl/ir_imm_decode.sv - LC-3b instruction latch, immediate extractor and SEXT control, two-entry skid buffer.
// Optional ILLEGAL_TRAP_EN: reserved opcodes raise illegal and hold the head until flush or reset.
module ir_imm_decode #(
  parameter int         PC_W         = 16,
  parameter logic [3:0] ILLEGAL_CONT = 4'd15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_ir,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_opcode,
  output logic [15:0]     imm_raw,
  output logic [3:0]      sext_cont,
  output logic            lshf1,
  output logic            has_imm,
  output logic            illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [15:0]     ir;
    logic [PC_W-1:0] pc;
    logic [15:0]     imm;
    logic [3:0]      cont;
    logic            lshf1;
    logic            has_imm;
    logic            illegal;
  } head_t;

  function automatic head_t decode(input logic [15:0] ir, input logic [PC_W-1:0] pc);
    head_t h;
    h.ir      = ir;
    h.pc      = pc;
    h.imm     = '0;
    h.cont    = 4'd15;
    h.lshf1   = 1'b0;
    h.has_imm = 1'b0;
    h.illegal = 1'b0;
    unique case (ir[15:12])
      4'b0000, 4'b1110: begin h.imm = {7'b0, ir[8:0]}; h.cont = 4'd8; h.lshf1 = 1'b1; h.has_imm = 1'b1; end
      4'b0001, 4'b0101, 4'b1001:
        if (ir[5]) begin h.imm = {11'b0, ir[4:0]}; h.cont = 4'd4; h.has_imm = 1'b1; end
      4'b0010, 4'b0011: begin h.imm = {10'b0, ir[5:0]}; h.cont = 4'd5; h.has_imm = 1'b1; end
      4'b0110, 4'b0111: begin h.imm = {10'b0, ir[5:0]}; h.cont = 4'd5; h.lshf1 = 1'b1; h.has_imm = 1'b1; end
      4'b0100:
        if (ir[11]) begin h.imm = {5'b0, ir[10:0]}; h.cont = 4'd10; h.lshf1 = 1'b1; h.has_imm = 1'b1; end
      4'b1101: begin h.imm = {12'b0, ir[3:0]}; h.has_imm = 1'b1; end
      4'b1111: begin h.imm = {8'b0, ir[7:0]}; h.lshf1 = 1'b1; h.has_imm = 1'b1; end
      4'b1010, 4'b1011: begin
        h.cont = ILLEGAL_CONT;
`ifdef ILLEGAL_TRAP_EN
        h.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
    return h;
  endfunction

  state_t          state_q, state_d;
  head_t           head_q, head_d;
  logic [15:0]     skid_ir_q, skid_ir_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  // An illegal head never pops; it is only cleared by flush or reset.
  assign pop       = out_valid & out_ready & ~head_q.illegal;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin head_d = decode(in_instr, in_pc); state_d = ONE; end
        ONE: begin
          if (push && pop) begin
            head_d = decode(in_instr, in_pc);
          end else if (push) begin
            skid_ir_d = in_instr;
            skid_pc_d = in_pc;
            state_d   = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin head_d = decode(skid_ir_q, skid_pc_q); state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '{ir: '0, pc: '0, imm: '0, cont: 4'd15, lshf1: 1'b0, has_imm: 1'b0, illegal: 1'b0};
      skid_ir_q  <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_ir_q  <= skid_ir_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_ir     = head_q.ir;
  assign out_pc     = head_q.pc;
  assign out_opcode = head_q.ir[15:12];
  assign imm_raw    = head_q.imm;
  assign sext_cont  = head_q.cont;
  assign lshf1      = head_q.lshf1;
  assign has_imm    = head_q.has_imm;
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = head_q.illegal;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_ir_imm_decode.sv
// tb/tb_ir_imm_decode.sv - self-checking bench for ir_imm_decode against a queue-based reference model.
module tb_ir_imm_decode;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr, in_pc, out_ir, out_pc, imm_raw;
  logic [3:0]  out_opcode, sext_cont;
  logic        lshf1, has_imm, illegal;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ir_imm_decode #(.PC_W(16), .ILLEGAL_CONT(4'd15)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .out_opcode(out_opcode), .imm_raw(imm_raw), .sext_cont(sext_cont),
    .lshf1(lshf1), .has_imm(has_imm), .illegal(illegal)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } ent_t;

  typedef struct packed {
    logic [15:0] imm;
    logic [3:0]  cont;
    logic        lshf1;
    logic        has;
    logic        ill;
  } exp_t;

  ent_t mq[$];

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Field width n selects the low n bits of the instruction as the raw immediate.
  function automatic exp_t ref_dec(input logic [15:0] ir);
    exp_t e;
    int   n;
    int   op;
    op = int'(ir[15:12]);
    n = 0;
    e.cont = 4'd15; e.lshf1 = 1'b0; e.has = 1'b0; e.ill = 1'b0;
    if (op == 0 || op == 14) begin n = 9; e.cont = 8; e.lshf1 = 1; end
    else if ((op == 1 || op == 5 || op == 9) && ir[5]) begin n = 5; e.cont = 4; end
    else if (op == 2 || op == 3) begin n = 6; e.cont = 5; end
    else if (op == 6 || op == 7) begin n = 6; e.cont = 5; e.lshf1 = 1; end
    else if (op == 4 && ir[11]) begin n = 11; e.cont = 10; e.lshf1 = 1; end
    else if (op == 13) n = 4;
    else if (op == 15) begin n = 8; e.lshf1 = 1; end
    else if (op == 10 || op == 11) e.ill = TRAP_EN;
    e.has = (n > 0);
    e.imm = 16'(ir & ((32'd1 << n) - 32'd1));
    return e;
  endfunction

  function automatic bit head_held();
    return TRAP_EN && mq.size() > 0 && (mq[0].ir[15:12] == 4'hA || mq[0].ir[15:12] == 4'hB);
  endfunction

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic rdy, input logic fl);
    bit   push, pop;
    ent_t e;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    push = v && (mq.size() < 2);
    pop  = (mq.size() > 0) && rdy && !head_held();
    @(posedge clk); #1;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin e.ir = ins; e.pc = pc; mq.push_back(e); end
    end
  endtask

  task automatic test_reset();
    logic [57:0] got;
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 16'($urandom); in_pc = 16'($urandom); out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {out_valid, in_ready, out_ir, out_pc, imm_raw, sext_cont, lshf1, has_imm, illegal};
    vecs++;
    if (got !== {1'b0, 1'b1, 48'h0, 4'hF, 3'b0}) begin
      errs++; $display("FAIL reset_state got=%h exp=%h", got, {1'b0, 1'b1, 48'h0, 4'hF, 3'b0});
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    mq.delete();
  endtask

  task automatic test_add_br();
    step(1, 16'h1261, 16'h3000, 1, 0);
    vecs++;
    if ({out_valid, imm_raw, sext_cont, lshf1, has_imm} !== {1'b1, 16'h0001, 4'd4, 1'b0, 1'b1}) begin
      errs++; $display("FAIL add_imm got v=%b imm=%h cont=%0d l=%b h=%b exp v=1 imm=0001 cont=4 l=0 h=1",
                       out_valid, imm_raw, sext_cont, lshf1, has_imm);
    end
    step(1, 16'h0FFF, 16'h3002, 1, 0);
    vecs++;
    if ({out_valid, out_ir, imm_raw, sext_cont, lshf1, has_imm} !== {1'b1, 16'h0FFF, 16'h01FF, 4'd8, 1'b1, 1'b1}) begin
      errs++; $display("FAIL br_offset got ir=%h imm=%h cont=%0d l=%b h=%b exp ir=0fff imm=01ff cont=8 l=1 h=1",
                       out_ir, imm_raw, sext_cont, lshf1, has_imm);
    end
    step(0, 16'h0, 16'h0, 1, 0);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    step(1, 16'h2AAA, 16'h0100, 0, 0);
    step(1, 16'h7BBB, 16'h0102, 0, 0);
    vecs++;
    if ({in_ready, out_valid, out_ir} !== {1'b0, 1'b1, 16'h2AAA}) begin
      errs++; $display("FAIL bp_full got rdy=%b v=%b ir=%h exp rdy=0 v=1 ir=2aaa", in_ready, out_valid, out_ir);
    end
    step(1, 16'h5555, 16'h0104, 1, 0);
    vecs++;
    if ({in_ready, out_valid, out_ir, out_pc} !== {1'b1, 1'b1, 16'h7BBB, 16'h0102}) begin
      errs++; $display("FAIL bp_second got rdy=%b v=%b ir=%h pc=%h exp rdy=1 v=1 ir=7bbb pc=0102",
                       in_ready, out_valid, out_ir, out_pc);
    end
    step(0, 16'h0, 16'h0, 1, 0);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] w [10];
    for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      step(1, w[i], 16'(i * 2), 1, 0);
      vecs++;
      if ({out_valid, in_ready, out_ir} !== {1'b1, 1'b1, w[i]}) begin
        errs++; $display("FAIL stream_%0d got v=%b rdy=%b ir=%h exp v=1 rdy=1 ir=%h",
                         i, out_valid, in_ready, out_ir, w[i]);
      end
    end
    step(0, 16'h0, 16'h0, 1, 0);
  endtask

  task automatic test_flush();
    step(1, 16'h1111, 16'h0, 0, 0);
    step(1, 16'h2222, 16'h0, 0, 0);
    step(1, 16'h3333, 16'h0, 1, 1);
    vecs++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errs++; $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    step(0, 16'h0, 16'h0, 1, 0);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_noemit got=%b exp=0", out_valid); end
  endtask

  task automatic test_reserved();
    step(1, 16'hA000, 16'h0200, 1, 0);
    vecs++;
    if ({out_valid, imm_raw, sext_cont, has_imm, illegal} !== {1'b1, 16'h0, 4'd15, 1'b0, TRAP_EN}) begin
      errs++; $display("FAIL reserved got v=%b imm=%h cont=%0d h=%b ill=%b exp v=1 imm=0000 cont=15 h=0 ill=%b",
                       out_valid, imm_raw, sext_cont, has_imm, illegal, TRAP_EN);
    end
    step(0, 16'h0, 16'h0, 1, 0);
    vecs++;
    if (out_valid !== TRAP_EN) begin
      errs++; $display("FAIL reserved_hold got=%b exp=%b", out_valid, TRAP_EN);
    end
    step(0, 16'h0, 16'h0, 1, 1);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reserved_flush got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [58:0] got, exp;
    exp_t        e;
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if (TRAP_EN && ins[15:13] == 3'b101) ins[14] = 1'b1;
      step(logic'($urandom_range(0, 3) != 0), ins, 16'($urandom),
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 19) == 0));
      vecs++;
      if ({out_valid, in_ready} !== {mq.size() > 0, mq.size() < 2}) begin
        errs++; $display("FAIL rand_hs_%0d got v=%b rdy=%b exp v=%b rdy=%b",
                         i, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
      end
      if (mq.size() > 0) begin
        e   = ref_dec(mq[0].ir);
        exp = {mq[0].ir, mq[0].pc, mq[0].ir[15:12], e.imm, e.cont, e.lshf1, e.has, e.ill};
        got = {out_ir, out_pc, out_opcode, imm_raw, sext_cont, lshf1, has_imm, illegal};
        vecs++;
        if (got !== exp) begin errs++; $display("FAIL rand_head_%0d got=%h exp=%h", i, got, exp); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    test_reset();
    test_add_br();
    test_backpressure();
    test_stream();
    test_flush();
    test_reserved();
    test_random();
    step(1, 16'h1234, 16'h0, 0, 0);
    step(1, 16'h5678, 16'h0, 0, 0);
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
